// File: rtl/mux_21_arbiter.sv
// rtl/mux_21_arbiter.sv - two-requester arbiter with minimum grant length, round-robin ties and registered mux output
module mux_21_arbiter #(
  parameter int DATA_W   = 1,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              sel,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [DATA_W-1:0] out,
  output logic              out_vld
);

  // Grant counter is wide enough to reach HOLD_CYC-1; a one-cycle hold still
  // needs a 1-bit counter that simply never leaves zero.
  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYC - 1);

  // Encoding of the round-robin history bit: which side was granted last.
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                sel_q, sel_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                vld_q, vld_d;

  logic                hold_done;
  logic                grant_entry;

  assign hold_done = (cnt_q == CNT_MAX);

  // Next-state logic: grants are committed until the hold expires, then the
  // other side (if requesting) takes over without passing through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = (last_q == LAST_B) ? GNT_A : GNT_B;
        end else if (req_a) begin
          state_d = GNT_A;
        end else if (req_b) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (hold_done) begin
          if (req_b) begin
            state_d = GNT_B;
          end else if (!req_a) begin
            state_d = IDLE;
          end
        end
      end
      GNT_B: begin
        if (hold_done) begin
          if (req_a) begin
            state_d = GNT_A;
          end else if (!req_b) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping: a fresh grant restarts the hold counter, records the
  // winner for round-robin and moves the mux select; otherwise count up to saturation.
  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    grant_entry = (state_d != IDLE) && (state_d != state_q);
    if (grant_entry) begin
      cnt_d  = '0;
      last_d = (state_d == GNT_B) ? LAST_B : LAST_A;
      sel_d  = (state_d == GNT_B);
    end else if ((state_q != IDLE) && !hold_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Data capture follows the grant that is active during the current cycle;
  // IDLE freezes the last captured value.
  always_comb begin
    out_d = out_q;
    case (state_q)
      GNT_A:   out_d = in_a;
      GNT_B:   out_d = in_b;
      default: out_d = out_q;
    endcase
    vld_d = (state_q != IDLE);
  end

  // State and output registers; reset takes effect immediately, even mid-grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_B;
      sel_q   <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt_a   = (state_q == GNT_A);
  assign gnt_b   = (state_q == GNT_B);
  assign sel     = sel_q;
  assign out     = out_q;
  assign out_vld = vld_q;

endmodule
